// File: rtl/l2_cache_if.sv
// l2_cache_if: the L2's two line-wide buses, upstream arbiter port (mem_*) and downstream memory port (pmem_*).
// Ports: master = environment side (arbiter + physical memory), slave = the cache itself.
// All signals are combinational wires; timing is defined by l2_cache.
interface l2_cache_if;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/l2_cache.sv
// l2_cache: 2-way set-associative write-back, write-allocate L2 with LRU and one miss in flight.
// Latency: hit 0 cycles past request (mem_resp same cycle); clean miss fill+1; dirty miss wb+fill+1.
// Backpressure: requests are held until mem_resp; pmem strobes are held until pmem_resp.
// Ports: clk, rst_n (synchronous, active-low), bus (l2_cache_if.slave), and when L2_PERF_CNT_EN
// is defined, hit_count / miss_count / wb_count saturating 16-bit event counters.
module l2_cache #(
  parameter int SETS     = 8,
  parameter int OFFSET_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  l2_cache_if.slave   bus
`ifdef L2_PERF_CNT_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
  output logic [15:0] wb_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 16 - OFFSET_W - IDX_W;

  typedef enum logic [1:0] {CHECK, WB, FILL} state_t;

  state_t             state;
  logic [127:0]       data_arr [2][SETS];
  logic [TAG_W-1:0]   tag_arr  [2][SETS];
  logic [SETS-1:0]    valid [2];
  logic [SETS-1:0]    dirty [2];
  logic [SETS-1:0]    lru;          // per set: index of the least recently used way

  // Miss context is latched so a request dropped mid-miss still finishes cleanly.
  logic [TAG_W-1:0]   rtag;
  logic [IDX_W-1:0]   ridx;
  logic               vway;
  logic               after_fill;   // first CHECK cycle after a fill (completion, not a fresh hit)

  logic               req;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit0, hit1, hit, hit_way;
  logic [127:0]       hit_line;
  logic               unused_offset;

  assign req      = bus.mem_read | bus.mem_write;
  assign idx      = bus.mem_address[OFFSET_W +: IDX_W];
  assign tag      = bus.mem_address[15 -: TAG_W];
  assign hit0     = valid[0][idx] && (tag_arr[0][idx] == tag);
  assign hit1     = valid[1][idx] && (tag_arr[1][idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_line = hit_way ? data_arr[1][idx] : data_arr[0][idx];
  assign unused_offset = ^bus.mem_address[OFFSET_W-1:0];

  // Outputs decode from state; gating with rst_n keeps them at 0 throughout reset.
  always_comb begin
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    if (rst_n) begin
      case (state)
        CHECK: begin
          if (req && hit) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = hit_line;
          end
        end
        WB: begin
          bus.pmem_write   = 1'b1;
          bus.pmem_address = {tag_arr[vway][ridx], ridx, {OFFSET_W{1'b0}}};
          bus.pmem_wdata   = data_arr[vway][ridx];
        end
        FILL: begin
          bus.pmem_read    = 1'b1;
          bus.pmem_address = {rtag, ridx, {OFFSET_W{1'b0}}};
        end
        default: ;
      endcase
    end
  end

  // Line data and tags carry no reset; only valid/dirty/lru are cleared.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CHECK && req && hit && bus.mem_write)
        data_arr[hit_way][idx] <= bus.mem_wdata;
      if (state == FILL && bus.pmem_resp) begin
        data_arr[vway][ridx] <= bus.pmem_rdata;
        tag_arr[vway][ridx]  <= rtag;
      end
    end
  end

`ifdef L2_PERF_CNT_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
  assign wb_count   = wb_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CHECK;
      valid[0]   <= '0;
      valid[1]   <= '0;
      dirty[0]   <= '0;
      dirty[1]   <= '0;
      lru        <= '0;
      rtag       <= '0;
      ridx       <= '0;
      vway       <= 1'b0;
      after_fill <= 1'b0;
`ifdef L2_PERF_CNT_EN
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      wb_cnt     <= '0;
`endif
    end else begin
      case (state)
        CHECK: begin
          after_fill <= 1'b0;
          if (req && hit) begin
            lru[idx] <= ~hit_way;
            if (bus.mem_write) dirty[hit_way][idx] <= 1'b1;
          end else if (req) begin
            rtag  <= tag;
            ridx  <= idx;
            vway  <= lru[idx];
            state <= (valid[lru[idx]][idx] && dirty[lru[idx]][idx]) ? WB : FILL;
          end
        end
        WB: begin
          if (bus.pmem_resp) begin
            dirty[vway][ridx] <= 1'b0;
            state             <= FILL;
          end
        end
        FILL: begin
          if (bus.pmem_resp) begin
            valid[vway][ridx] <= 1'b1;
            dirty[vway][ridx] <= 1'b0;
            after_fill        <= 1'b1;
            state             <= CHECK;
          end
        end
        default: state <= CHECK;
      endcase
`ifdef L2_PERF_CNT_EN
      if (state == CHECK && req && hit && !after_fill && hit_cnt != 16'hFFFF)
        hit_cnt <= hit_cnt + 16'd1;
      if (state == CHECK && req && !hit && miss_cnt != 16'hFFFF)
        miss_cnt <= miss_cnt + 16'd1;
      if (state == WB && bus.pmem_resp && wb_cnt != 16'hFFFF)
        wb_cnt <= wb_cnt + 16'd1;
`endif
    end
  end
endmodule
